ps2_cmd_scheduler: RTL

PS2_CMD_SCHEDULER -- requirements
Module: ps2_cmd_scheduler

---
 rtl/ps2_cmd_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ps2_cmd_scheduler
// Description : Arbitrates two requesters onto one PS/2 host controller and
//               runs each transaction (command byte, optional argument byte)
//               through send / release / acknowledge, with resend retries,
//               bus-fault retries and an acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_cmd_scheduler #(
    parameter logic [19:0] ACK_TIMEOUT = 20'd750000,
    parameter int          MAX_RETRY   = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic [7:0] arg0,
    input  logic [7:0] arg1,
    input  logic [1:0] has_arg,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en
);

    localparam int                   c_RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);
    localparam logic [19:0]          c_ACK_LAST  = ACK_TIMEOUT - 20'd1;
    localparam logic [7:0]           c_ACK       = 8'hFA;
    localparam logic [7:0]           c_RESEND    = 8'hFE;
    localparam logic [1:0]           c_ERR_BUS   = 2'b01;
    localparam logic [1:0]           c_ERR_ACK   = 2'b10;
    localparam logic [1:0]           c_ERR_RETRY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_RELEASE  = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_NEXT     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_gnt;
    logic [7:0]             r_cmd;
    logic [7:0]             r_arg;
    logic                   r_has_arg;
    logic                   r_idx;
    logic [c_RETRY_W-1:0]   r_retry;
    logic                   r_bus_fault;
    logic [19:0]            r_ack_cnt;
    logic [7:0]             r_last_byte;

    logic                   w_grant;
    logic                   w_retry;
    logic                   w_to_arg;
    logic                   w_clr_ack;
    logic                   w_finish_ok;
    logic                   w_finish_err;
    logic [1:0]             w_err_code;
    logic                   w_can_retry;
    logic [7:0]             w_cur_byte;
    logic                   w_is_ack;
    logic                   w_is_resend;

    assign w_can_retry = (r_retry < c_MAX_RETRY);
    assign w_cur_byte  = r_idx ? r_arg : r_cmd;
    assign w_is_ack    = received_data_en && (received_data == c_ACK);
    assign w_is_resend = received_data_en && (received_data == c_RESEND);

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus single-cycle control strobes for the datapath
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_retry      = 1'b0;
        w_to_arg     = 1'b0;
        w_clr_ack    = 1'b0;
        w_finish_ok  = 1'b0;
        w_finish_err = 1'b0;
        w_err_code   = 2'b00;
        unique case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_grant      = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                // Fault and success in the same cycle resolve as a fault
                if (error_communication_timed_out || command_was_sent) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (r_bus_fault) begin
                    if (w_can_retry) begin
                        w_retry      = 1'b1;
                        w_state_next = S_SEND;
                    end else begin
                        // Bus fault on the final attempt is reported as a bus fault
                        w_finish_err = 1'b1;
                        w_err_code   = c_ERR_BUS;
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_clr_ack    = 1'b1;
                    w_state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (w_is_ack) begin
                    w_state_next = S_NEXT;
                end else if (w_is_resend) begin
                    if (w_can_retry) begin
                        w_retry      = 1'b1;
                        w_state_next = S_SEND;
                    end else begin
                        w_finish_err = 1'b1;
                        w_err_code   = c_ERR_RETRY;
                        w_state_next = S_IDLE;
                    end
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    w_finish_err = 1'b1;
                    w_err_code   = c_ERR_ACK;
                    w_state_next = S_IDLE;
                end
            end
            S_NEXT: begin
                if (r_has_arg && !r_idx) begin
                    w_to_arg     = 1'b1;
                    w_state_next = S_SEND;
                end else begin
                    w_finish_ok  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Transaction context: owner, latched bytes, retry/index/fault, ack counter
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_gnt       <= 2'b00;
            r_cmd       <= 8'h00;
            r_arg       <= 8'h00;
            r_has_arg   <= 1'b0;
            r_idx       <= 1'b0;
            r_retry     <= '0;
            r_bus_fault <= 1'b0;
            r_ack_cnt   <= 20'd0;
            r_last_byte <= 8'h00;
        end else begin
            if (w_grant) begin
                // Bit 0 wins whenever it is set
                r_gnt       <= req[0] ? 2'b01 : 2'b10;
                r_cmd       <= req[0] ? cmd0 : cmd1;
                r_arg       <= req[0] ? arg0 : arg1;
                r_has_arg   <= req[0] ? has_arg[0] : has_arg[1];
                r_idx       <= 1'b0;
                r_retry     <= '0;
                r_bus_fault <= 1'b0;
            end
            if (w_finish_ok || w_finish_err) begin
                r_gnt <= 2'b00;
            end
            if (w_retry) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_to_arg) begin
                r_idx <= 1'b1;
            end
            if ((r_state == S_SEND) && (error_communication_timed_out || command_was_sent)) begin
                r_bus_fault <= error_communication_timed_out;
            end
            // Remember the byte on the wire so the_command holds outside SEND
            if (r_state == S_SEND) begin
                r_last_byte <= w_cur_byte;
            end
            if (w_clr_ack) begin
                r_ack_cnt <= 20'd0;
            end else if (r_state == S_WAIT_ACK) begin
                r_ack_cnt <= r_ack_cnt + 20'd1;
            end
        end
    end

    assign gnt          = r_gnt;
    assign done         = w_finish_ok  ? r_gnt : 2'b00;
    assign err          = w_finish_err ? r_gnt : 2'b00;
    assign err_code     = w_err_code;
    assign busy         = (r_state != S_IDLE);
    assign send_command = (r_state == S_SEND);
    assign the_command  = send_command ? w_cur_byte : r_last_byte;

endmodule
`default_nettype wire
